// File: rtl/m_countdown_ctrl_pkg.sv
// m_countdown_ctrl_pkg: shared state encoding and BCD digit limits for the countdown timer
package m_countdown_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;
  localparam logic [3:0] BCD_ONES_MAX = 4'd9;
  localparam logic [3:0] BCD_TENS_MAX = 4'd5;
endpackage

// File: rtl/m_countdown_ctrl_if.sv
// m_countdown_ctrl_if: button pulses in, BCD digits and status flags out
//   btn_start/btn_clear/btn_min/btn_sec : single-cycle request pulses
//   min_tens/min_ones/sec_tens/sec_ones  : MM:SS as four BCD digits
//   running/done/alarm                   : status flags
interface m_countdown_ctrl_if;
  logic       btn_start;
  logic       btn_clear;
  logic       btn_min;
  logic       btn_sec;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       done;
  logic       alarm;
  modport master (
    output btn_start, btn_clear, btn_min, btn_sec,
    input  min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
  );
  modport slave (
    input  btn_start, btn_clear, btn_min, btn_sec,
    output min_tens, min_ones, sec_tens, sec_ones, running, done, alarm
  );
endinterface

// File: rtl/m_tick_gen.sv
// m_tick_gen: modulo-DIV enable counter producing a one-cycle tick on its last count
//   clk, rst_n : clock, synchronous active-low reset
//   en         : advance the counter (holds otherwise)
//   clr        : force the counter to zero
//   tick       : high while count == DIV-1 and en
module m_tick_gen #(
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = (clr || tick) ? '0 : en ? cnt_q + W'(1) : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/m_countdown_ctrl.sv
// m_countdown_ctrl: MM:SS kitchen-timer controller with set, start/pause, clear and alarm
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of m_countdown_ctrl_if (buttons in, digits and flags out)
module m_countdown_ctrl
  import m_countdown_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 50000000,
  parameter int ALARM_SEC = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  m_countdown_ctrl_if.slave   bus
);
  localparam int AW = $clog2(ALARM_SEC + 1);
  function automatic logic [7:0] bcd_inc59(input logic [7:0] v);
    return (v[3:0] != BCD_ONES_MAX) ? {v[7:4], v[3:0] + 4'd1} :
           (v[7:4] != BCD_TENS_MAX) ? {v[7:4] + 4'd1, 4'd0} : 8'h00;
  endfunction
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = BCD_ONES_MAX;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = BCD_TENS_MAX;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = BCD_ONES_MAX;
          mt = (mt != 4'd0) ? mt - 4'd1 : 4'd0;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction
  state_t        state_q, state_d;
  logic [15:0]   time_q, time_d, time_dec;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          running_q, running_d, done_q, done_d, alarm_q, alarm_d;
  logic          tick, tick_en, tick_clr;
  m_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );
  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    acnt_d   = acnt_q;
    done_d   = 1'b0;
    time_dec = bcd_dec(time_q);
    case (state_q)
      IDLE: begin
        if (bus.btn_clear) time_d = '0;
        else if (bus.btn_start) state_d = (time_q != '0) ? RUN : IDLE;
        else begin
          if (bus.btn_min) time_d[15:8] = bcd_inc59(time_q[15:8]);
          if (bus.btn_sec) time_d[7:0]  = bcd_inc59(time_q[7:0]);
        end
      end
      RUN: begin
        if (bus.btn_clear) begin
          state_d = IDLE;
          time_d  = '0;
        end else begin
          if (bus.btn_start) state_d = PAUSE;
          if (tick) begin
            time_d = time_dec;
            if (time_dec == '0) begin
              state_d = ALARM;
              done_d  = 1'b1;
              acnt_d  = '0;
            end
          end
        end
      end
      PAUSE: begin
        if (bus.btn_clear) begin
          state_d = IDLE;
          time_d  = '0;
        end else if (bus.btn_start) state_d = RUN;
      end
      default: begin
        if (bus.btn_clear || bus.btn_start) state_d = IDLE;
        else if (tick) begin
          acnt_d = acnt_q + AW'(1);
          if (acnt_q == AW'(ALARM_SEC - 1)) state_d = IDLE;
        end
      end
    endcase
    running_d = (state_d == RUN);
    alarm_d   = (state_d == ALARM);
    tick_en   = (state_q == RUN) || (state_q == ALARM);
    tick_clr  = (state_q == IDLE) || (state_d == IDLE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      time_q    <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      acnt_q    <= acnt_d;
      running_q <= running_d;
      done_q    <= done_d;
      alarm_q   <= alarm_d;
    end
  end
  assign {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones} = time_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;
endmodule

// File: tb/tb_m_countdown_ctrl.sv
// tb_m_countdown_ctrl: directed self-checking bench for m_countdown_ctrl (TICK_DIV=4, ALARM_SEC=2)
module tb_m_countdown_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [15:0] digits;
  m_countdown_ctrl_if bus();
  m_countdown_ctrl #(.TICK_DIV(4), .ALARM_SEC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  assign digits = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic press(input logic s, input logic c, input logic m, input logic sc);
    @(negedge clk);
    bus.btn_start = s; bus.btn_clear = c; bus.btn_min = m; bus.btn_sec = sc;
    @(negedge clk);
    bus.btn_start = 1'b0; bus.btn_clear = 1'b0; bus.btn_min = 1'b0; bus.btn_sec = 1'b0;
  endtask
  task automatic press_n(input logic m, input logic sc, input int n);
    repeat (n) press(1'b0, 1'b0, m, sc);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    cycles(3);
    checks++;
    if ({digits, bus.running, bus.done, bus.alarm} !== 19'h0) begin
      errors++; $display("FAIL reset got %h/%b%b%b exp 0000/000", digits, bus.running, bus.done, bus.alarm);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_count_down;
    press_n(1'b0, 1'b1, 3);
    press_n(1'b1, 1'b0, 1);
    checks++;
    if (digits !== 16'h0103) begin errors++; $display("FAIL set_0103 got %h exp 0103", digits); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.running !== 1'b1) begin errors++; $display("FAIL run_flag got %b exp 1", bus.running); end
    cycles(3);
    checks++;
    if (digits !== 16'h0103) begin errors++; $display("FAIL before_tick got %h exp 0103", digits); end
    cycles(1);
    checks++;
    if (digits !== 16'h0102) begin errors++; $display("FAIL tick4 got %h exp 0102", digits); end
    cycles(8);
    checks++;
    if (digits !== 16'h0100) begin errors++; $display("FAIL tick12 got %h exp 0100", digits); end
    cycles(4);
    checks++;
    if (digits !== 16'h0059) begin errors++; $display("FAIL borrow got %h exp 0059", digits); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({digits, bus.running} !== 17'h0) begin errors++; $display("FAIL clear_run got %h/%b exp 0000/0", digits, bus.running); end
  endtask
  task automatic test_alarm;
    press_n(1'b0, 1'b1, 1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(3);
    checks++;
    if ({digits, bus.done} !== {16'h0001, 1'b0}) begin errors++; $display("FAIL pre_alarm got %h/%b exp 0001/0", digits, bus.done); end
    cycles(1);
    checks++;
    if ({digits, bus.done, bus.alarm, bus.running} !== {16'h0000, 3'b110}) begin
      errors++; $display("FAIL alarm_entry got %h/%b%b%b exp 0000/110", digits, bus.done, bus.alarm, bus.running);
    end
    cycles(1);
    checks++;
    if ({bus.done, bus.alarm} !== 2'b01) begin errors++; $display("FAIL done_width got %b%b exp 01", bus.done, bus.alarm); end
    cycles(6);
    checks++;
    if (bus.alarm !== 1'b1) begin errors++; $display("FAIL alarm_hold got %b exp 1", bus.alarm); end
    cycles(1);
    checks++;
    if ({bus.alarm, bus.running, digits} !== 18'h0) begin errors++; $display("FAIL alarm_end got %b%b/%h exp 00/0000", bus.alarm, bus.running, digits); end
  endtask
  task automatic test_pause;
    press_n(1'b0, 1'b1, 5);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({digits, bus.running} !== {16'h0005, 1'b0}) begin errors++; $display("FAIL pause got %h/%b exp 0005/0", digits, bus.running); end
    cycles(20);
    checks++;
    if (digits !== 16'h0005) begin errors++; $display("FAIL pause_hold got %h exp 0005", digits); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(1);
    checks++;
    if ({digits, bus.running} !== {16'h0005, 1'b1}) begin errors++; $display("FAIL resume_early got %h/%b exp 0005/1", digits, bus.running); end
    cycles(1);
    checks++;
    if (digits !== 16'h0004) begin errors++; $display("FAIL resume_tick got %h exp 0004", digits); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic test_set_wrap;
    press_n(1'b0, 1'b1, 59);
    checks++;
    if (digits !== 16'h0059) begin errors++; $display("FAIL sec59 got %h exp 0059", digits); end
    press_n(1'b0, 1'b1, 1);
    checks++;
    if (digits !== 16'h0000) begin errors++; $display("FAIL sec_wrap got %h exp 0000", digits); end
    press_n(1'b1, 1'b0, 61);
    checks++;
    if (digits !== 16'h0100) begin errors++; $display("FAIL min_wrap got %h exp 0100", digits); end
    press_n(1'b1, 1'b1, 1);
    checks++;
    if (digits !== 16'h0201) begin errors++; $display("FAIL min_sec_same got %h exp 0201", digits); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(5);
    checks++;
    if ({digits, bus.running, bus.alarm} !== 18'h0) begin errors++; $display("FAIL start_zero got %h/%b%b exp 0000/00", digits, bus.running, bus.alarm); end
  endtask
  task automatic test_clear_start;
    press_n(1'b0, 1'b1, 3);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(2);
    press(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({digits, bus.running} !== 17'h0) begin errors++; $display("FAIL clr_start got %h/%b exp 0000/0", digits, bus.running); end
    cycles(5);
    checks++;
    if ({digits, bus.running, bus.done} !== 18'h0) begin errors++; $display("FAIL clr_start_idle got %h/%b%b exp 0000/00", digits, bus.running, bus.done); end
  endtask
  task automatic test_reset_mid_run;
    press_n(1'b1, 1'b0, 10);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    cycles(4);
    checks++;
    if (digits !== 16'h0959) begin errors++; $display("FAIL ten_min got %h exp 0959", digits); end
    rst_n = 1'b0;
    cycles(1);
    rst_n = 1'b1;
    checks++;
    if ({digits, bus.running, bus.done, bus.alarm} !== 19'h0) begin
      errors++; $display("FAIL mid_reset got %h/%b%b%b exp 0000/000", digits, bus.running, bus.done, bus.alarm);
    end
    cycles(8);
    checks++;
    if ({digits, bus.running, bus.done, bus.alarm} !== 19'h0) begin
      errors++; $display("FAIL post_reset got %h/%b%b%b exp 0000/000", digits, bus.running, bus.done, bus.alarm);
    end
  endtask
  initial begin
    bus.btn_start = 1'b0; bus.btn_clear = 1'b0; bus.btn_min = 1'b0; bus.btn_sec = 1'b0;
    test_reset;
    test_count_down;
    test_alarm;
    test_pause;
    test_set_wrap;
    test_clear_start;
    test_reset_mid_run;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
